// File: rtl/display_pkg.sv
// Shared types, segment glyphs and digit-range limits for the multiplexed
// 7-segment display scanner.
package display_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [2:0] digit_idx_t;

  localparam int NUM_DIGITS = 6;
  localparam int LSD_MAX    = 9;
  localparam int MSD_MAX_SM = 5;
  localparam int MSD_MAX_H  = 2;

  // Active-low segments, bit0 = a .. bit6 = g.
  localparam seg_t SEG_0    = 7'h40;
  localparam seg_t SEG_1    = 7'h79;
  localparam seg_t SEG_2    = 7'h24;
  localparam seg_t SEG_3    = 7'h30;
  localparam seg_t SEG_4    = 7'h19;
  localparam seg_t SEG_5    = 7'h12;
  localparam seg_t SEG_6    = 7'h02;
  localparam seg_t SEG_7    = 7'h78;
  localparam seg_t SEG_8    = 7'h00;
  localparam seg_t SEG_9    = 7'h10;
  localparam seg_t SEG_DASH = 7'h3F;
  localparam seg_t SEG_OFF  = 7'h7F;

  // Largest legal value of the digit shown in a given slot (even slots are lsds).
  function automatic logic [3:0] digit_max(digit_idx_t idx);
    case (idx)
      3'd0, 3'd2, 3'd4: digit_max = 4'(LSD_MAX);
      3'd1, 3'd3:       digit_max = 4'(MSD_MAX_SM);
      default:          digit_max = 4'(MSD_MAX_H);
    endcase
  endfunction

endpackage

// File: rtl/display_scan_if.sv
// Digit bus from the time counters: six BCD digits, ss/mm/hh least and most
// significant. The counters drive it (master), the display scanner reads it (slave).
interface display_scan_if;

  logic [3:0] s_lsd;
  logic [2:0] s_msd;
  logic [3:0] m_lsd;
  logic [2:0] m_msd;
  logic [3:0] h_lsd;
  logic [2:0] h_msd;

  modport master (output s_lsd, s_msd, m_lsd, m_msd, h_lsd, h_msd);
  modport slave  (input  s_lsd, s_msd, m_lsd, m_msd, h_lsd, h_msd);

endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder; any value above i_max
// (or above 9) shows a dash so corrupted counters are visible on the board.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic [3:0] i_max,
  output seg_t       o_seg
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    o_seg = SEG_DASH;
    if (i_bcd <= i_max) begin
      case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/display_scan.sv
// Six-digit multiplexed common-anode display scanner with per-frame digit snapshot
// and anti-ghost blanking. Optional blinking hh.mm.ss separators: DISPLAY_DP_BLINK_EN.
module display_scan
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic           main_clock,
  input  logic           main_reset,
  display_scan_if.slave  digits,
  output seg_t           seg_n,
  output logic           dp_n,
  output logic [5:0]     an_n,
  output logic           frame_tick
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  digit_idx_t       r_idx;
  logic [3:0]       r_snap [NUM_DIGITS];
  logic [5:0]       r_an;
  seg_t             r_seg;
  logic             r_tick;

  logic             w_slot_end;
  logic             w_frame_end;
  logic             w_blank;
  logic [3:0]       w_digit;
  seg_t             w_seg;
  logic [5:0]       w_an;

  assign w_slot_end  = (r_div == DIV_W'(REFRESH_DIV - 1));
  assign w_frame_end = w_slot_end && (r_idx == digit_idx_t'(NUM_DIGITS - 1));
  assign w_blank     = (r_div < DIV_W'(BLANK_CYCLES));
  assign w_an        = ~(6'b1 << r_idx);

  always_comb begin
    w_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == digit_idx_t'(i)) w_digit = r_snap[i];
    end
  end

  seg7_decoder u_dec (
    .i_bcd (w_digit),
    .i_max (digit_max(r_idx)),
    .o_seg (w_seg)
  );

  // Slot timing: divider within a slot, slot index across the frame.
  always_ff @(posedge main_clock or negedge main_reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!main_reset) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_div <= '0;
      r_idx <= (r_idx == digit_idx_t'(NUM_DIGITS - 1)) ? '0 : r_idx + 3'd1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Digits are frozen once per frame so a counter rollover never tears a frame.
  always_ff @(posedge main_clock or negedge main_reset) begin
    // NOTE: the snapshot array is reset on purpose: the first frame after reset must read 00:00:00.
    if (!main_reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_snap[i] <= '0;
    end else if (w_frame_end) begin
      r_snap[0] <= digits.s_lsd;
      r_snap[1] <= {1'b0, digits.s_msd};
      r_snap[2] <= digits.m_lsd;
      r_snap[3] <= {1'b0, digits.m_msd};
      r_snap[4] <= digits.h_lsd;
      r_snap[5] <= {1'b0, digits.h_msd};
    end
  end

  always_ff @(posedge main_clock or negedge main_reset) begin
    if (!main_reset) begin
      r_an   <= 6'h3F;
      r_seg  <= SEG_OFF;
      r_tick <= 1'b0;
    end else begin
      r_an   <= w_blank ? 6'h3F : w_an;
      r_seg  <= w_blank ? SEG_OFF : w_seg;
      r_tick <= w_frame_end;
    end
  end

  assign an_n       = r_an;
  assign seg_n      = r_seg;
  assign frame_tick = r_tick;

`ifdef DISPLAY_DP_BLINK_EN
  logic r_blink;
  logic r_dp;
  logic w_dp_lit;

  // Phase flips only when the snapshotted seconds digit actually moved.
  assign w_dp_lit = !w_blank && (r_idx == 3'd2 || r_idx == 3'd4) && r_blink;

  always_ff @(posedge main_clock or negedge main_reset) begin
    if (!main_reset) begin
      r_blink <= 1'b0;
      r_dp    <= 1'b1;
    end else begin
      if (w_frame_end && (digits.s_lsd != r_snap[0])) r_blink <= ~r_blink;
      r_dp <= ~w_dp_lit;
    end
  end

  assign dp_n = r_dp;
`else
  assign dp_n = 1'b1;
`endif

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: directed and random digit streams compared
// each cycle against a frame/slot arithmetic model of the display.
module tb_display_scan;
  import display_pkg::*;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = RD * NUM_DIGITS;

  logic       main_clock = 1'b0;
  logic       main_reset = 1'b0;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [5:0] an_n;
  logic       frame_tick;

  display_scan_if bus ();

  display_scan #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .main_clock (main_clock),
    .main_reset (main_reset),
    .digits     (bus),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  always #5 main_clock = ~main_clock;

  localparam logic [6:0] FONT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam int MAX_OF [6] = '{9, 5, 9, 5, 9, 2};

  int n_checks = 0;
  int n_pass   = 0;
  int k;
  int cur    [6];
  int m_snap [6];
`ifdef DISPLAY_DP_BLINK_EN
  bit m_blink;
`endif

  function automatic logic [6:0] exp_glyph(int pos, int val);
    if (val > MAX_OF[pos]) return 7'h3F;
    return FONT[val];
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at edge %0d: got %02h, expected %02h", tag, k, obs, exp);
  endtask

  task automatic set_digits(int sl, int sm, int ml, int mm, int hl, int hm);
    cur[0] = sl; cur[1] = sm; cur[2] = ml; cur[3] = mm; cur[4] = hl; cur[5] = hm;
    bus.s_lsd = 4'(sl);
    bus.s_msd = 3'(sm);
    bus.m_lsd = 4'(ml);
    bus.m_msd = 3'(mm);
    bus.h_lsd = 4'(hl);
    bus.h_msd = 3'(hm);
  endtask

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < NUM_DIGITS; i++) m_snap[i] = 0;
`ifdef DISPLAY_DP_BLINK_EN
    m_blink = 1'b0;
`endif
  endtask

  task automatic check_idle(string tag);
    check({tag, "_an"},   8'(an_n),       8'h3F);
    check({tag, "_seg"},  8'(seg_n),      8'h7F);
    check({tag, "_dp"},   8'(dp_n),       8'h01);
    check({tag, "_tick"}, 8'(frame_tick), 8'h00);
  endtask

  // One clock edge: predict what the registered outputs show after edge k, then
  // let the frame snapshot (taken on the last cycle of every frame) update the model.
  task automatic step();
    int         pos;
    int         slot;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_tick;
    @(posedge main_clock);
    k++;
    pos  = (k - 1) % RD;
    slot = ((k - 1) / RD) % NUM_DIGITS;
    if (pos < BC) begin
      e_an  = 6'h3F;
      e_seg = 7'h7F;
    end else begin
      e_an  = 6'(63 - (1 << slot));
      e_seg = exp_glyph(slot, m_snap[slot]);
    end
    e_dp = 1'b1;
`ifdef DISPLAY_DP_BLINK_EN
    if (pos >= BC && (slot == 2 || slot == 4)) e_dp = ~m_blink;
`endif
    e_tick = (k % FRAME == 0);
    if (e_tick) begin
`ifdef DISPLAY_DP_BLINK_EN
      if (cur[0] != m_snap[0]) m_blink = ~m_blink;
`endif
      for (int i = 0; i < NUM_DIGITS; i++) m_snap[i] = cur[i];
    end
    #1;
    check("an_n",       8'(an_n),       8'(e_an));
    check("seg_n",      8'(seg_n),      8'(e_seg));
    check("dp_n",       8'(dp_n),       8'(e_dp));
    check("frame_tick", 8'(frame_tick), 8'(e_tick));
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  // Advance until the scanner state is slot s, divider p (bounded).
  task automatic run_to_slot(int s, int p);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((k / RD) % NUM_DIGITS == s && k % RD == p) return;
      step();
    end
    n_checks++;
    $error("FAIL run_to_slot: slot %0d div %0d not reached, edge %0d", s, p, k);
  endtask

  initial begin
    set_digits(0, 0, 0, 0, 0, 0);
    model_reset();
    main_reset = 1'b0;
    #23;
    check_idle("reset_hold");
    @(negedge main_clock);
    main_reset = 1'b1;
    check_idle("post_release");

    // 12:34:56 after a first frame of 00:00:00.
    set_digits(6, 5, 4, 3, 2, 1);
    run(2 * FRAME);

    // Seconds change mid-frame stays hidden until the next snapshot.
    run_to_slot(3, 4);
    set_digits(7, 5, 4, 3, 2, 1);
    run(2 * FRAME);

    // Out-of-range digits on slots 0, 3 and 5.
    set_digits(10, 5, 4, 6, 2, 3);
    run(2 * FRAME);

    // Random digit streams, including out-of-range codes, changing at random times.
    repeat (40) begin
      set_digits($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 15),
                 $urandom_range(0, 7),  $urandom_range(0, 15), $urandom_range(0, 7));
      run($urandom_range(5, 40));
    end

    // Reset in the middle of slot 4 takes effect without a clock edge.
    run_to_slot(4, 3);
    #2;
    main_reset = 1'b0;
    #1;
    check_idle("mid_reset");
    model_reset();
    repeat (2) @(posedge main_clock);
    #1;
    check_idle("reset_clocked");
    @(negedge main_clock);
    main_reset = 1'b1;
    set_digits(9, 5, 9, 5, 3, 2);
    run(FRAME + RD);

    // Seconds stepping 0 -> 1 -> 2 across frames drives the separator phase.
    set_digits(0, 0, 0, 0, 0, 0);
    run(2 * FRAME);
    set_digits(1, 0, 0, 0, 0, 0);
    run(2 * FRAME);
    set_digits(2, 0, 0, 0, 0, 0);
    run(2 * FRAME);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
